// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory request/grant/in-order response and the
// decode-side handoff of buffered instructions.
interface inst_fetch_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  inst_req;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_gnt;
   logic                  inst_rvalid;
   logic [DATA_WIDTH-1:0] inst_rdata;
   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_inst;
   logic [ADDR_WIDTH-1:0] if_pc;
   logic [ADDR_WIDTH-1:0] if_pc_next;
   logic                  id_ready;

   modport master (
      output inst_req, inst_addr, if_valid, if_inst, if_pc, if_pc_next,
      input  inst_gnt, inst_rvalid, inst_rdata, id_ready
   );

   modport slave (
      input  inst_req, inst_addr, if_valid, if_inst, if_pc, if_pc_next,
      output inst_gnt, inst_rvalid, inst_rdata, id_ready
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// MIPS fetch stage: owns the fetch PC, issues pipelined memory requests under a
// credit limit and buffers returned instructions with their PCs toward decode.
module inst_fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  cpu_rst_n,
   input  logic                  cpu_en,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   inst_fetch_if.master          bus,
   output logic [ADDR_WIDTH-1:0] dbg_fetch_pc
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_C = FIFO_DEPTH[CNT_W:0];
   localparam logic [CNT_W-1:0] FULL_C  = FIFO_DEPTH[CNT_W-1:0];

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic [ADDR_WIDTH-1:0] target_pc;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      outstanding_nxt;
   logic [CNT_W-1:0]      drop_cnt;
   logic [CNT_W-1:0]      fifo_cnt;
   logic [CNT_W:0]        inflight;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;

   assign target_pc = redirect_pc & ~ADDR_WIDTH'(3);

   // Credit: in-flight requests plus buffered entries never exceed the FIFO,
   // so every response has a slot waiting for it.
   assign inflight      = {1'b0, outstanding} + {1'b0, fifo_cnt};
   assign bus.inst_req  = cpu_rst_n & cpu_en & ~redirect & (inflight < DEPTH_C);
   assign bus.inst_addr = fetch_pc;
   assign accept        = bus.inst_req & bus.inst_gnt;

   assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(bus.inst_rvalid);

   // A response in the redirect cycle belongs to the old path whatever drop_cnt says.
   assign push      = bus.inst_rvalid & ~redirect & (drop_cnt == '0);
   assign fifo_full = (fifo_cnt == FULL_C);

   assign bus.if_valid   = (fifo_cnt != '0);
   assign pop            = bus.if_valid & bus.id_ready & cpu_en & ~redirect;
   assign bus.if_inst    = fifo_inst[rd_ptr];
   assign bus.if_pc      = fifo_pc[rd_ptr];
   assign bus.if_pc_next = fifo_pc[rd_ptr] + ADDR_WIDTH'(4);
   assign dbg_fetch_pc   = fetch_pc;

   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect) begin
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
            drop_cnt <= outstanding_nxt;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            if (push) begin
               resp_pc <= resp_pc + ADDR_WIDTH'(4);
               wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (bus.inst_rvalid && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CNT_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Buffer storage carries data only and is never cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr] <= bus.inst_rdata;
         fifo_pc[wr_ptr]   <= resp_pc;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!cpu_rst_n)
      !(push && !pop && fifo_full));
   a_drop_bounded: assert property (@(posedge clk) disable iff (!cpu_rst_n)
      drop_cnt <= outstanding);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a queue-based in-order memory model.
module tb_inst_fetch_unit;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk         = 1'b0;
   logic          cpu_rst_n   = 1'b0;
   logic          cpu_en      = 1'b0;
   logic          redirect    = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [AW-1:0] dbg_fetch_pc;
   logic          mem_gnt     = 1'b1;
   logic          mem_rvalid  = 1'b0;
   logic [DW-1:0] mem_rdata   = '0;
   logic          id_ready    = 1'b0;
   int            mem_lat     = 1;
   int            mem_cyc     = 0;
   logic [AW-1:0] mq_addr[$];
   int            mq_due[$];

   int vectors     = 0;
   int miscompares = 0;

   inst_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   assign bus.inst_gnt    = mem_gnt;
   assign bus.inst_rvalid = mem_rvalid;
   assign bus.inst_rdata  = mem_rdata;
   assign bus.id_ready    = id_ready;

   inst_fetch_unit #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk          (clk),
      .cpu_rst_n    (cpu_rst_n),
      .cpu_en       (cpu_en),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .bus          (bus),
      .dbg_fetch_pc (dbg_fetch_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Instruction memory: grant accepted at edge t returns mem_lat cycles later.
   always @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         mq_addr.delete();
         mq_due.delete();
         mem_rvalid <= 1'b0;
      end else begin
         mem_cyc <= mem_cyc + 1;
         if (bus.inst_req && bus.inst_gnt) begin
            mq_addr.push_back(bus.inst_addr);
            mq_due.push_back(mem_cyc + mem_lat - 1);
         end
         if (mq_addr.size() != 0 && mq_due[0] <= mem_cyc) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= inst_of(mq_addr[0]);
            mq_addr.pop_front();
            mq_due.pop_front();
         end else begin
            mem_rvalid <= 1'b0;
         end
      end
   end

   task automatic do_reset(input int lat);
      @(negedge clk);
      cpu_rst_n = 1'b0;
      cpu_en    = 1'b1;
      redirect  = 1'b0;
      id_ready  = 1'b1;
      mem_gnt   = 1'b1;
      mem_lat   = lat;
      repeat (2) @(negedge clk);
      cpu_rst_n = 1'b1;
   endtask

   task automatic test_reset;
      cpu_rst_n = 1'b0;
      cpu_en    = 1'b1;
      id_ready  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (bus.inst_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", bus.inst_req); end
      vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", bus.if_valid); end
      vectors++; if (dbg_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", dbg_fetch_pc); end
   endtask

   task automatic test_stream;
      do_reset(1);
      for (int k = 0; k < 10; k++) begin
         #1;
         vectors++; if (bus.inst_req !== 1'b1) begin miscompares++; $display("FAIL stream_req k=%0d got %b exp 1", k, bus.inst_req); end
         vectors++; if (bus.inst_addr !== AW'(4 * k)) begin miscompares++; $display("FAIL stream_addr k=%0d got %h exp %h", k, bus.inst_addr, 4 * k); end
         if (k >= 2) begin
            vectors++; if (bus.if_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid k=%0d got %b exp 1", k, bus.if_valid); end
            vectors++; if (bus.if_pc !== AW'(4 * (k - 2))) begin miscompares++; $display("FAIL stream_pc k=%0d got %h exp %h", k, bus.if_pc, 4 * (k - 2)); end
            vectors++; if (bus.if_inst !== inst_of(AW'(4 * (k - 2)))) begin miscompares++; $display("FAIL stream_inst k=%0d got %h exp %h", k, bus.if_inst, inst_of(AW'(4 * (k - 2)))); end
            vectors++; if (bus.if_pc_next !== AW'(4 * (k - 1))) begin miscompares++; $display("FAIL stream_pcnext k=%0d got %h exp %h", k, bus.if_pc_next, 4 * (k - 1)); end
         end else begin
            vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL stream_novalid k=%0d got %b exp 0", k, bus.if_valid); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      int n_req;
      logic [AW-1:0] exp_pc;
      do_reset(1);
      id_ready = 1'b0;
      n_req = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (bus.inst_req && mem_gnt) n_req++;
         if (k >= 4) begin
            vectors++; if (bus.inst_req !== 1'b0) begin miscompares++; $display("FAIL bp_req k=%0d got %b exp 0", k, bus.inst_req); end
            vectors++; if (dbg_fetch_pc !== 32'h10) begin miscompares++; $display("FAIL bp_hold k=%0d got %h exp 10", k, dbg_fetch_pc); end
         end
         @(negedge clk);
      end
      #1;
      vectors++; if (n_req !== 4) begin miscompares++; $display("FAIL bp_nreq got %0d exp 4", n_req); end
      vectors++; if (bus.if_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head got %h exp 0", bus.if_pc); end
      id_ready = 1'b1;
      exp_pc = 32'h0;
      for (int k = 0; k < 12; k++) begin
         #1;
         vectors++; if (bus.if_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid k=%0d got %b exp 1", k, bus.if_valid); end
         vectors++; if (bus.if_pc !== exp_pc) begin miscompares++; $display("FAIL bp_pc k=%0d got %h exp %h", k, bus.if_pc, exp_pc); end
         vectors++; if (bus.if_inst !== inst_of(exp_pc)) begin miscompares++; $display("FAIL bp_inst k=%0d got %h exp %h", k, bus.if_inst, inst_of(exp_pc)); end
         exp_pc += 4;
         @(negedge clk);
      end
   endtask

   task automatic test_redirect;
      logic [AW-1:0] exp_pc;
      int first, seen;
      do_reset(4);
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++; if (bus.inst_addr !== AW'(4 * k)) begin miscompares++; $display("FAIL rd_addr k=%0d got %h exp %h", k, bus.inst_addr, 4 * k); end
         @(negedge clk);
      end
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      vectors++; if (bus.inst_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_gate got %b exp 0", bus.inst_req); end
      @(negedge clk);
      redirect = 1'b0;
      #1;
      vectors++; if (bus.inst_addr !== 32'h100) begin miscompares++; $display("FAIL rd_newaddr got %h exp 100", bus.inst_addr); end
      exp_pc = 32'h100; first = -1; seen = 0;
      for (int k = 4; k < 20; k++) begin
         if (k != 4) #1;
         if (bus.if_valid) begin
            vectors++; if (bus.if_pc !== exp_pc) begin miscompares++; $display("FAIL rd_pc k=%0d got %h exp %h", k, bus.if_pc, exp_pc); end
            vectors++; if (bus.if_inst !== inst_of(exp_pc)) begin miscompares++; $display("FAIL rd_inst k=%0d got %h exp %h", k, bus.if_inst, inst_of(exp_pc)); end
            if (first < 0) first = k;
            seen++;
            exp_pc += 4;
         end
         @(negedge clk);
      end
      vectors++; if (first !== 9) begin miscompares++; $display("FAIL rd_first got %0d exp 9", first); end
      vectors++; if (seen < 4) begin miscompares++; $display("FAIL rd_seen got %0d exp >=4", seen); end
   endtask

   task automatic test_redirect_flush;
      logic [AW-1:0] exp_pc;
      int first;
      do_reset(2);
      id_ready = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin miscompares++; $display("FAIL fl_pre got v=%b pc=%h exp v=1 pc=0", bus.if_valid, bus.if_pc); end
      redirect = 1'b1;
      redirect_pc = 32'h200;
      id_ready = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL fl_flushed got %b exp 0", bus.if_valid); end
      exp_pc = 32'h200; first = -1;
      for (int k = 5; k < 18; k++) begin
         if (k != 5) #1;
         if (bus.if_valid) begin
            vectors++; if (bus.if_pc !== exp_pc) begin miscompares++; $display("FAIL fl_pc k=%0d got %h exp %h", k, bus.if_pc, exp_pc); end
            if (first < 0) first = k;
            exp_pc += 4;
         end
         @(negedge clk);
      end
      vectors++; if (first !== 8) begin miscompares++; $display("FAIL fl_first got %0d exp 8", first); end
   endtask

   task automatic test_cpu_en;
      logic [AW-1:0] exp_pc;
      int first, seen;
      do_reset(2);
      repeat (2) @(negedge clk);
      cpu_en = 1'b0;
      for (int k = 2; k < 7; k++) begin
         #1;
         vectors++; if (bus.inst_req !== 1'b0) begin miscompares++; $display("FAIL en_req k=%0d got %b exp 0", k, bus.inst_req); end
         vectors++; if (dbg_fetch_pc !== 32'h8) begin miscompares++; $display("FAIL en_hold k=%0d got %h exp 8", k, dbg_fetch_pc); end
         if (k >= 3) begin
            vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin miscompares++; $display("FAIL en_buf k=%0d got v=%b pc=%h exp v=1 pc=0", k, bus.if_valid, bus.if_pc); end
         end
         @(negedge clk);
      end
      cpu_en = 1'b1;
      exp_pc = 32'h0; first = -1; seen = 0;
      for (int k = 7; k < 19; k++) begin
         #1;
         if (bus.if_valid) begin
            vectors++; if (bus.if_pc !== exp_pc) begin miscompares++; $display("FAIL en_pc k=%0d got %h exp %h", k, bus.if_pc, exp_pc); end
            if (first < 0) first = k;
            seen++;
            exp_pc += 4;
         end
         @(negedge clk);
      end
      vectors++; if (first !== 7) begin miscompares++; $display("FAIL en_first got %0d exp 7", first); end
      vectors++; if (seen < 6) begin miscompares++; $display("FAIL en_seen got %0d exp >=6", seen); end
   endtask

   task automatic test_back_to_back;
      logic [AW-1:0] exp_pc;
      int first;
      do_reset(2);
      repeat (2) @(negedge clk);
      redirect = 1'b1;
      redirect_pc = 32'h300;
      @(negedge clk);
      redirect_pc = 32'h400;
      #1;
      vectors++; if (dbg_fetch_pc !== 32'h300) begin miscompares++; $display("FAIL b2b_first got %h exp 300", dbg_fetch_pc); end
      @(negedge clk);
      redirect = 1'b0;
      #1;
      vectors++; if (bus.inst_addr !== 32'h400) begin miscompares++; $display("FAIL b2b_addr got %h exp 400", bus.inst_addr); end
      exp_pc = 32'h400; first = -1;
      for (int k = 4; k < 16; k++) begin
         if (k != 4) #1;
         if (bus.if_valid) begin
            vectors++; if (bus.if_pc !== exp_pc) begin miscompares++; $display("FAIL b2b_pc k=%0d got %h exp %h", k, bus.if_pc, exp_pc); end
            if (first < 0) first = k;
            exp_pc += 4;
         end
         @(negedge clk);
      end
      vectors++; if (first !== 7) begin miscompares++; $display("FAIL b2b_latency got %0d exp 7", first); end
   endtask

   task automatic test_async_reset;
      do_reset(1);
      repeat (5) @(negedge clk);
      #1;
      vectors++; if (bus.if_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre got %b exp 1", bus.if_valid); end
      #1;
      cpu_rst_n = 1'b0;
      #1;
      vectors++; if (bus.inst_req !== 1'b0) begin miscompares++; $display("FAIL ar_req got %b exp 0", bus.inst_req); end
      vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b exp 0", bus.if_valid); end
      vectors++; if (dbg_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL ar_pc got %h exp 0", dbg_fetch_pc); end
      repeat (2) @(negedge clk);
      cpu_rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         vectors++; if (bus.inst_addr !== AW'(4 * k)) begin miscompares++; $display("FAIL ar_addr k=%0d got %h exp %h", k, bus.inst_addr, 4 * k); end
         if (k >= 2) begin
            vectors++; if (bus.if_valid !== 1'b1 || bus.if_pc !== AW'(4 * (k - 2))) begin miscompares++; $display("FAIL ar_pcseq k=%0d got v=%b pc=%h exp pc=%h", k, bus.if_valid, bus.if_pc, 4 * (k - 2)); end
         end else begin
            vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL ar_novalid k=%0d got %b exp 0", k, bus.if_valid); end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_flush();
      test_cpu_en();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
